pixel_trace_scheduler: RTL and testbench
========================================

PIXEL_TRACE_SCHEDULER -- requirements
Module: pixel_trace_scheduler

Interface
REQ-001 Parameter NUM_SPHERES, default 4: number of spheres evaluated per pixel; range 1..16.
REQ-002 Parameter DIST_W, default 64: width of distance values, unsigned fixed point.
REQ-003 Parameter FAR_DIST, default 64'hEFFF_FFFF_FFFF_FFFF: "no hit" distance.
REQ-004 Parameters H_RES = 640 and V_RES = 480: raster size.
REQ-005 Parameter RAY_LAT, default 2: minimum number of RAY_WAIT cycles, range 1..15.
REQ-006 Clk  in  1  system clock; all state changes on the rising edge.
REQ-007 Reset_n  in  1  asynchronous, active-low reset.
REQ-008 Start  in  1  begin a frame; honoured only in IDLE.
REQ-009 Abort  in  1  synchronous abandon of the frame from any state.
REQ-010 Ray_Valid  in  1  ray for the current Pixel_X/Pixel_Y is valid.
REQ-011 Collision  in  1  the sphere at Sphere_Index is hit.
REQ-012 Curr_Dist  in  DIST_W  hit distance for Sphere_Index.
REQ-013 Write_Ready  in  1  frame buffer accepts the write.
REQ-014 Pixel_X, Pixel_Y  out  10 each  current pixel; also the write address.
REQ-015 Sphere_Index  out  clog2(NUM_SPHERES), min 1  sphere register read index.
REQ-016 Write_Valid  out  1  pixel result is valid.
REQ-017 Write_Hit  out  1  a sphere was hit for this pixel.
REQ-018 Write_Index  out  Sphere_Index width  index of the nearest sphere.
REQ-019 Best_Dist  out  DIST_W  nearest distance found so far.
REQ-020 Busy  out  1  high in every state except IDLE.
REQ-021 Frame_Done  out  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-022 The state machine SHALL have five states: IDLE, RAY_WAIT, SPH_ADDR, SPH_EVAL, WRITE.
REQ-023 IDLE: Start=1 -> RAY_WAIT with Pixel_X=Pixel_Y=0 and the dwell counter cleared.
REQ-024 RAY_WAIT: the dwell counter increments each cycle.
- Leave for SPH_ADDR once the counter is at least RAY_LAT-1 and Ray_Valid=1; otherwise hold.
- On leaving: sphere counter=0, Best_Dist=FAR_DIST, Write_Index=0, Write_Hit=0.
REQ-025 SPH_ADDR: drive Sphere_Index=sphere counter, then go to SPH_EVAL.
REQ-026 SPH_EVAL: drive the same Sphere_Index and sample Collision and Curr_Dist.
- If Collision=1 and Curr_Dist < Best_Dist (unsigned, strict): Best_Dist<=Curr_Dist, Write_Index<=counter, Write_Hit<=1.
- Ties keep the lower index.
REQ-027 SPH_EVAL exit: counter=NUM_SPHERES-1 -> WRITE; otherwise increment the counter and go to SPH_ADDR.
REQ-028 WRITE: Write_Valid=1.
- Pixel_X, Pixel_Y, Write_Hit, Write_Index and Best_Dist are held stable until Write_Valid & Write_Ready.
REQ-029 On WRITE acceptance, pixels advance in raster order.
- Pixel_X increments; at H_RES-1 it wraps to 0 and Pixel_Y increments; then -> RAY_WAIT with the dwell counter cleared.
REQ-030 On acceptance at (H_RES-1, V_RES-1): Pixel_X=Pixel_Y=0, Frame_Done=1 for one cycle, -> IDLE.
REQ-031 Latency with Ray_Valid and Write_Ready held high: RAY_LAT + 2*NUM_SPHERES + 1 cycles per pixel (11 for the defaults).
REQ-032 Abort=1 -> IDLE next cycle from any state, with Pixel_X/Y=0 and no Frame_Done.
- Abort and a WRITE acceptance in the same cycle: the write completes, Abort still wins, no Frame_Done.
REQ-033 Start=1 outside IDLE SHALL be ignored; Start and Abort together in IDLE: stay IDLE.
REQ-034 Sphere_Index SHALL be 0 outside SPH_ADDR and SPH_EVAL.
REQ-035 Write_Valid SHALL be 0 outside WRITE.

Reset
REQ-036 Reset_n=0 SHALL immediately force, asynchronously:
- state IDLE;
- Pixel_X, Pixel_Y, Sphere_Index, Write_Index = 0;
- Write_Valid, Write_Hit, Busy, Frame_Done = 0;
- Best_Dist = FAR_DIST;
- all counters = 0.
REQ-037 Deassertion mid-frame SHALL NOT resume the frame; a new Start is required.

Verification
REQ-038 Reset: assert Reset_n=0 mid-SPH_EVAL -> all outputs at REQ-036 values in the same cycle; after release, Busy=0 until Start.
REQ-039 Latency: defaults, Ray_Valid=Write_Ready=1, Start at cycle 0, only sphere 2 collides with Curr_Dist=0x5_0000_0000.
- Write_Valid at cycle 11 with (0,0), Write_Hit=1, Write_Index=2, Best_Dist=0x5_0000_0000.
REQ-040 Nearest selection and ties:
- sphere0=0x200, sphere2=0x80 -> Write_Index=2.
- spheres 1 and 3 both 0x100 -> Write_Index=1.
- no collisions -> Write_Hit=0, Best_Dist=FAR_DIST.
REQ-041 Backpressure: Write_Ready=0 for 5 cycles.
- Write_Valid and all write fields stable for those 5 cycles; acceptance -> Pixel (1,0).
- Ray_Valid=0 for 4 cycles in RAY_WAIT -> SPH_ADDR delayed by 4 cycles.
REQ-042 Raster boundaries:
- acceptance at (639,0) -> (0,1).
- acceptance at (639,479) -> Frame_Done single pulse, Busy=0, Pixel (0,0).
- Start during Busy -> ignored.
REQ-043 Abort:
- Abort in SPH_ADDR -> IDLE next cycle, no Frame_Done.
- Abort coincident with a WRITE acceptance -> one write observed, then IDLE.

Source files
------------

// File: rtl/pixel_trace_scheduler.sv
// Per-pixel sphere-intersection scheduler: walks the raster, reads each sphere's
// hit result in turn and hands the nearest hit to the frame buffer.
module pixel_trace_scheduler #(
    parameter int                NUM_SPHERES = 4,
    parameter int                DIST_W      = 64,
    parameter logic [DIST_W-1:0] FAR_DIST    = 64'hEFFF_FFFF_FFFF_FFFF,
    parameter int                H_RES       = 640,
    parameter int                V_RES       = 480,
    parameter int                RAY_LAT     = 2,
    localparam int               SW          = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Ray_Valid,
    input  logic              Collision,
    input  logic [DIST_W-1:0] Curr_Dist,
    input  logic              Write_Ready,
    output logic [9:0]        Pixel_X,
    output logic [9:0]        Pixel_Y,
    output logic [SW-1:0]     Sphere_Index,
    output logic              Write_Valid,
    output logic              Write_Hit,
    output logic [SW-1:0]     Write_Index,
    output logic [DIST_W-1:0] Best_Dist,
    output logic              Busy,
    output logic              Frame_Done
);

    typedef enum logic [2:0] {
        IDLE,
        RAY_WAIT,
        SPH_ADDR,
        SPH_EVAL,
        WRITE
    } state_t;

    localparam logic [3:0]    DWELL_MIN = 4'(RAY_LAT - 1);
    localparam logic [SW-1:0] LAST_SPH  = SW'(NUM_SPHERES - 1);
    localparam logic [9:0]    LAST_X    = 10'(H_RES - 1);
    localparam logic [9:0]    LAST_Y    = 10'(V_RES - 1);

    state_t     state;
    logic [3:0] dwell;
    logic       closer_hit;

    // Strict compare: an equal distance from a later sphere never displaces the earlier one.
    assign closer_hit = Collision && (Curr_Dist < Best_Dist);

    // Sphere_Index doubles as the sphere counter; it returns to zero whenever the
    // FSM leaves the evaluation loop, so it reads 0 in every other state.
    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; the Abort block below relies on last-assignment-wins ordering.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            dwell        <= '0;
            Pixel_X      <= '0;
            Pixel_Y      <= '0;
            Sphere_Index <= '0;
            Write_Valid  <= 1'b0;
            Write_Hit    <= 1'b0;
            Write_Index  <= '0;
            Best_Dist    <= FAR_DIST;
            Busy         <= 1'b0;
            Frame_Done   <= 1'b0;
        end else begin
            Frame_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= RAY_WAIT;
                        Busy    <= 1'b1;
                        Pixel_X <= '0;
                        Pixel_Y <= '0;
                        dwell   <= '0;
                    end
                end
                RAY_WAIT: begin
                    if (dwell != 4'hF) dwell <= dwell + 4'd1;
                    if ((dwell >= DWELL_MIN) && Ray_Valid) begin
                        state        <= SPH_ADDR;
                        Sphere_Index <= '0;
                        Best_Dist    <= FAR_DIST;
                        Write_Index  <= '0;
                        Write_Hit    <= 1'b0;
                    end
                end
                SPH_ADDR: state <= SPH_EVAL;
                SPH_EVAL: begin
                    if (closer_hit) begin
                        Best_Dist   <= Curr_Dist;
                        Write_Index <= Sphere_Index;
                        Write_Hit   <= 1'b1;
                    end
                    if (Sphere_Index == LAST_SPH) begin
                        state        <= WRITE;
                        Sphere_Index <= '0;
                        Write_Valid  <= 1'b1;
                    end else begin
                        state        <= SPH_ADDR;
                        Sphere_Index <= Sphere_Index + SW'(1);
                    end
                end
                WRITE: begin
                    if (Write_Ready) begin
                        Write_Valid <= 1'b0;
                        dwell       <= '0;
                        if (Pixel_X == LAST_X) begin
                            Pixel_X <= '0;
                            if (Pixel_Y == LAST_Y) begin
                                Pixel_Y    <= '0;
                                Frame_Done <= 1'b1;
                                Busy       <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                Pixel_Y <= Pixel_Y + 10'd1;
                                state   <= RAY_WAIT;
                            end
                        end else begin
                            Pixel_X <= Pixel_X + 10'd1;
                            state   <= RAY_WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Abort overrides everything above, including a same-cycle write acceptance.
            if (Abort) begin
                state        <= IDLE;
                Busy         <= 1'b0;
                Pixel_X      <= '0;
                Pixel_Y      <= '0;
                Sphere_Index <= '0;
                Write_Valid  <= 1'b0;
                Frame_Done   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_trace_scheduler.sv
// Directed bench for pixel_trace_scheduler: latency, nearest/tie selection, backpressure,
// raster wrap, abort and reset; a small-raster instance covers the end-of-frame pulse.
module tb_pixel_trace_scheduler;

    localparam logic [63:0] FAR = 64'hEFFF_FFFF_FFFF_FFFF;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start, Abort, Ray_Valid, Collision, Write_Ready;
    logic [63:0] Curr_Dist;
    logic [9:0]  Pixel_X, Pixel_Y;
    logic [1:0]  Sphere_Index, Write_Index;
    logic        Write_Valid, Write_Hit, Busy, Frame_Done;
    logic [63:0] Best_Dist;

    logic        Start2;
    logic [9:0]  Pixel_X2, Pixel_Y2;
    logic        Sphere_Index2, Write_Index2;
    logic        Write_Valid2, Write_Hit2, Busy2, Frame_Done2;
    logic [63:0] Best_Dist2;

    logic        hit_tbl  [4];
    logic [63:0] dist_tbl [4];

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    pixel_trace_scheduler dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
        .Ray_Valid(Ray_Valid), .Collision(Collision), .Curr_Dist(Curr_Dist),
        .Write_Ready(Write_Ready), .Pixel_X(Pixel_X), .Pixel_Y(Pixel_Y),
        .Sphere_Index(Sphere_Index), .Write_Valid(Write_Valid), .Write_Hit(Write_Hit),
        .Write_Index(Write_Index), .Best_Dist(Best_Dist), .Busy(Busy), .Frame_Done(Frame_Done)
    );

    // Shrunken raster so the end-of-frame path is reachable in a short run.
    pixel_trace_scheduler #(.NUM_SPHERES(1), .H_RES(8), .V_RES(4), .RAY_LAT(1)) dut_small (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start2), .Abort(1'b0),
        .Ray_Valid(Ray_Valid), .Collision(1'b0), .Curr_Dist(64'd0),
        .Write_Ready(Write_Ready), .Pixel_X(Pixel_X2), .Pixel_Y(Pixel_Y2),
        .Sphere_Index(Sphere_Index2), .Write_Valid(Write_Valid2), .Write_Hit(Write_Hit2),
        .Write_Index(Write_Index2), .Best_Dist(Best_Dist2), .Busy(Busy2), .Frame_Done(Frame_Done2)
    );

    // Sphere register file seen through the DUT's read index.
    always_comb begin
        Collision = hit_tbl[Sphere_Index];
        Curr_Dist = dist_tbl[Sphere_Index];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_spheres(input logic [3:0] hits, input logic [63:0] d0, input logic [63:0] d1,
                               input logic [63:0] d2, input logic [63:0] d3);
        for (int i = 0; i < 4; i++) hit_tbl[i] = hits[i];
        dist_tbl[0] = d0;
        dist_tbl[1] = d1;
        dist_tbl[2] = d2;
        dist_tbl[3] = d3;
    endtask

    // Counts negedges until Write_Valid; Start is dropped after the first one.
    task automatic wait_wv(output int cyc);
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
            Start = 1'b0;
        end while (!Write_Valid && cyc < 100);
        if (!Write_Valid) check("wv_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idx1();
        int n;
        n = 0;
        while (Sphere_Index != 2'd1 && n < 40) begin
            @(negedge Clk);
            n++;
            Start = 1'b0;
        end
        if (Sphere_Index != 2'd1) check("idx1_timeout", 64'(Sphere_Index), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int guard;
        logic [9:0]  snap_x, snap_y;
        logic [1:0]  snap_idx;
        logic [63:0] snap_dist;

        Reset_n = 1'b0; Start = 1'b0; Abort = 1'b0; Ray_Valid = 1'b1; Write_Ready = 1'b1;
        Start2 = 1'b0;
        set_spheres(4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
        repeat (2) @(negedge Clk);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_wv", 64'(Write_Valid), 64'd0);
        check("rst_best", Best_Dist, FAR);
        check("rst_xy", {44'd0, Pixel_Y, Pixel_X}, 64'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Pixel (0,0): only sphere 2 hits.
        set_spheres(4'b0100, 64'd0, 64'd0, 64'h5_0000_0000, 64'd0);
        Start = 1'b1;
        wait_wv(cyc);
        check("lat_cycles", 64'(cyc), 64'd11);
        check("lat_xy", {44'd0, Pixel_Y, Pixel_X}, 64'd0);
        check("lat_hit", 64'(Write_Hit), 64'd1);
        check("lat_idx", 64'(Write_Index), 64'd2);
        check("lat_dist", Best_Dist, 64'h5_0000_0000);

        // Pixel (1,0): nearest of two hits.
        set_spheres(4'b0101, 64'h200, 64'd0, 64'h80, 64'd0);
        wait_wv(cyc);
        check("near_cycles", 64'(cyc), 64'd11);
        check("near_x", 64'(Pixel_X), 64'd1);
        check("near_idx", 64'(Write_Index), 64'd2);
        check("near_dist", Best_Dist, 64'h80);

        // Pixel (2,0): tie keeps the lower index.
        set_spheres(4'b1010, 64'd0, 64'h100, 64'd0, 64'h100);
        wait_wv(cyc);
        check("tie_idx", 64'(Write_Index), 64'd1);
        check("tie_dist", Best_Dist, 64'h100);

        // Pixel (3,0): no collisions.
        set_spheres(4'b0000, 64'h10, 64'h10, 64'h10, 64'h10);
        wait_wv(cyc);
        check("miss_hit", 64'(Write_Hit), 64'd0);
        check("miss_dist", Best_Dist, FAR);
        check("miss_idx", 64'(Write_Index), 64'd0);

        // Pixel (4,0): Write_Ready low for 5 cycles of WRITE.
        set_spheres(4'b1000, 64'd0, 64'd0, 64'd0, 64'h33);
        @(negedge Clk);
        Write_Ready = 1'b0;
        wait_wv(cyc);
        snap_x = Pixel_X; snap_y = Pixel_Y; snap_idx = Write_Index; snap_dist = Best_Dist;
        check("bp_x", 64'(snap_x), 64'd4);
        check("bp_dist", snap_dist, 64'h33);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge Clk);
            check("bp_hold", {Write_Valid, Write_Hit, snap_idx == Write_Index,
                              snap_dist == Best_Dist, snap_x == Pixel_X, snap_y == Pixel_Y},
                  64'b111111);
        end
        Write_Ready = 1'b1;
        @(negedge Clk);
        check("bp_next_xy", {44'd0, Pixel_Y, Pixel_X}, {44'd0, 10'd0, 10'd5});
        check("bp_next_wv", 64'(Write_Valid), 64'd0);

        // Pixel (5,0): Ray_Valid low for the 4 cycles it would otherwise leave RAY_WAIT.
        set_spheres(4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
        cyc = 1;
        while (!Write_Valid && cyc < 100) begin
            Ray_Valid = (cyc >= 2 && cyc < 6) ? 1'b0 : 1'b1;
            @(negedge Clk);
            cyc++;
        end
        Ray_Valid = 1'b1;
        check("rv_delay_cycles", 64'(cyc), 64'd15);
        check("rv_x", 64'(Pixel_X), 64'd5);

        // Start while busy must not restart the frame.
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("busy_start_x", 64'(Pixel_X), 64'd6);
        check("busy_start_busy", 64'(Busy), 64'd1);

        // Run to the end of row 0.
        guard = 0;
        do begin
            wait_wv(cyc);
            guard++;
        end while (Pixel_X != 10'd639 && guard < 700);
        check("row_end_xy", {44'd0, Pixel_Y, Pixel_X}, {44'd0, 10'd0, 10'd639});
        @(negedge Clk);
        check("row_wrap_xy", {44'd0, Pixel_Y, Pixel_X}, {44'd0, 10'd1, 10'd0});
        check("row_wrap_fd", 64'(Frame_Done), 64'd0);

        // Abort in SPH_ADDR (first cycle Sphere_Index reads 1).
        wait_idx1();
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_xy", {44'd0, Pixel_Y, Pixel_X}, 64'd0);
        check("abort_fd", 64'(Frame_Done), 64'd0);
        check("abort_idx", 64'(Sphere_Index), 64'd0);

        // Start and Abort together in IDLE.
        Start = 1'b1; Abort = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Abort = 1'b0;
        check("start_abort_busy", 64'(Busy), 64'd0);

        // Abort coincident with a write acceptance.
        Start = 1'b1;
        wait_wv(cyc);
        check("abw_wv", 64'(Write_Valid), 64'd1);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        check("abw_after", {Write_Valid, Busy, Frame_Done}, 64'd0);
        check("abw_xy", {44'd0, Pixel_Y, Pixel_X}, 64'd0);
        cyc = 0;
        repeat (3) begin
            @(negedge Clk);
            if (Write_Valid) cyc++;
        end
        check("abw_no_more_writes", 64'(cyc), 64'd0);

        // Reset asserted mid SPH_EVAL with a pending hit.
        set_spheres(4'b0001, 64'h40, 64'd0, 64'd0, 64'd0);
        Start = 1'b1;
        @(negedge Clk);
        wait_idx1();
        @(negedge Clk);
        check("pre_rst_dist", Best_Dist, 64'h40);
        #2 Reset_n = 1'b0;
        #1;
        check("mid_rst_flags", {Write_Valid, Write_Hit, Busy, Frame_Done}, 64'd0);
        check("mid_rst_idx", {Sphere_Index, Write_Index}, 64'd0);
        check("mid_rst_dist", Best_Dist, FAR);
        check("mid_rst_xy", {44'd0, Pixel_Y, Pixel_X}, 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        check("post_rst_busy", 64'(Busy), 64'd0);

        // Small raster: end of frame at (7,3).
        Start2 = 1'b1;
        guard = 0;
        do begin
            @(negedge Clk);
            Start2 = 1'b0;
            guard++;
        end while (!(Write_Valid2 && Pixel_X2 == 10'd7 && Pixel_Y2 == 10'd3) && guard < 1000);
        check("frame_last_wv", 64'(Write_Valid2), 64'd1);
        check("frame_last_fd", 64'(Frame_Done2), 64'd0);
        @(negedge Clk);
        check("frame_done", 64'(Frame_Done2), 64'd1);
        check("frame_busy", 64'(Busy2), 64'd0);
        check("frame_xy", {44'd0, Pixel_Y2, Pixel_X2}, 64'd0);
        @(negedge Clk);
        check("frame_done_pulse", 64'(Frame_Done2), 64'd0);
        check("frame_stay_idle", 64'(Busy2), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
